guess_round_ctrl: RTL and testbench
===================================

// Module: guess_round_ctrl
// PURPOSE
//  Round sequencer for the Bulls and Cows game.
//  - Collects four one-cycle-qualified digit strobes into a 16-bit guess and fires a one-cycle check strobe at the scoring datapath.
//  - Waits for the scored strike/ball result, counts attempts and declares win or lose.
//  - Sits between the digit-decode/trigger path and the scoring, LED, LCD and step-motor blocks.
// PARAMETERS
//  MAX_TRIES    10  attempts allowed before lose; legal range 1..15
//  RESULT_TMO   15  cycles in WAIT without score_valid before abort; must be >=1
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous reset, active-high
//  digit_valid  in   1   one-cycle strobe, digit is valid
//  digit        in   4   decimal digit, legal values 0..9
//  clear        in   1   one-cycle strobe: discard entry, or restart after game end
//  score_valid  in   1   one-cycle strobe, strike/ball are valid
//  strike       in   4   strikes for the last guess
//  ball         in   4   balls for the last guess
//  guess        out  16  {d1,d2,d3,d4}; 4'hF marks an empty slot
//  check_en     out  1   one-cycle strobe to scoring datapath
//  entry_cnt    out  3   digits entered so far, 0..4
//  attempts     out  4   scored attempts this game
//  last_strike  out  4   latched strike of last scored guess
//  last_ball    out  4   latched ball of last scored guess
//  busy         out  1   high in CHECK and WAIT
//  reject       out  1   one-cycle pulse: input refused or result timed out
//  win          out  1   held high in WON
//  lose         out  1   held high in LOST
// BEHAVIOUR
//  Reset values:
//  - state=ENTRY, guess=16'hFFFF.
//  - entry_cnt=0, attempts=0, last_strike=0, last_ball=0.
//  - check_en, busy, reject, win and lose all 0.
//  Registered outputs: every output is registered; no input reaches an output combinationally.
//  States: ENTRY, CHECK, WAIT, WON, LOST.
//  ENTRY:
//  - digit_valid with digit<=9: write digit to nibble [15-4*entry_cnt -: 4]; entry_cnt+1.
//  - digit>9: ignored; reject=1 next cycle.
//  - After the 4th accepted digit the next state is CHECK, so the first check_en is 2 cycles after the final digit_valid.
//  - clear: guess=FFFF, entry_cnt=0. clear beats a simultaneous digit_valid.
//  CHECK: check_en=1 for exactly this cycle; busy=1; next state WAIT; the timeout counter is zeroed.
//  WAIT: busy=1; digit_valid is ignored with no reject.
//  - score_valid: latch strike/ball; attempts+1.
//    - strike==4: next state WON.
//    - else new attempts==MAX_TRIES: next state LOST.
//    - else: next state ENTRY with guess=FFFF and entry_cnt=0.
//  - RESULT_TMO cycles with no score_valid: reject pulse, then ENTRY with guess and entry_cnt cleared. attempts is unchanged.
//  - clear: abort to ENTRY with the same clearing and attempts unchanged. clear beats a simultaneous score_valid.
//  WON / LOST:
//  - win or lose is held; guess is held; digit_valid is ignored.
//  - clear: next state ENTRY with attempts=0, guess=FFFF, entry_cnt=0, win=0 and lose=0.
//  Strays: score_valid outside WAIT is ignored.
//  Timing: check_en, reject, win and lose change on the cycle after the causing input.
// CONFIGURATION
//  DUP_REJECT_EN defined:
//  - In ENTRY, a digit equal to any already-filled slot is refused.
//  - The refused digit raises a reject pulse; guess and entry_cnt are unchanged.
//  DUP_REJECT_EN undefined: duplicate digits are accepted normally.
// TESTING
//  1. rst high 1 cycle; then digits 1,2,3,4.
//     -> guess=16'h1234, entry_cnt=4, one check_en pulse 2 cycles after the digit-4 strobe.
//  2. WAIT, score_valid with strike=4.
//     -> win=1, attempts=1, last_strike=4.
//     -> clear -> win=0, attempts=0, guess=16'hFFFF.
//  3. MAX_TRIES=3; three guesses each scored strike=1, ball=2.
//     -> lose=1 after the third, attempts=3, last_ball=2.
//  4. digit 4'hA in ENTRY -> reject pulse, entry_cnt unchanged.
//     Digits 5,6 then clear together with a digit_valid -> guess=FFFF, entry_cnt=0.
//  5. WAIT with no score_valid for RESULT_TMO cycles -> reject pulse, ENTRY, attempts unchanged.
//     A late score_valid is then ignored.
//  6. DUP_REJECT_EN defined: digits 7,7 -> second 7 rejected, guess=16'h7FFF, entry_cnt=1.
//     Macro undefined: guess=16'h77FF, entry_cnt=2.

Source files
------------

// File: rtl/guess_round_ctrl.sv
// Bulls and Cows round sequencer: digit entry, check strobe, result wait, win/lose.
// Optional build macro DUP_REJECT_EN refuses a digit already present in the guess.
module guess_round_ctrl #(
   parameter int unsigned MAX_TRIES  = 10,
   parameter int unsigned RESULT_TMO = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        digit_valid,
   input  logic [3:0]  digit,
   input  logic        clear,
   input  logic        score_valid,
   input  logic [3:0]  strike,
   input  logic [3:0]  ball,
   output logic [15:0] guess,
   output logic        check_en,
   output logic [2:0]  entry_cnt,
   output logic [3:0]  attempts,
   output logic [3:0]  last_strike,
   output logic [3:0]  last_ball,
   output logic        busy,
   output logic        reject,
   output logic        win,
   output logic        lose
);

   localparam int unsigned TW = $clog2(RESULT_TMO + 1);

   typedef enum logic [2:0] {
      S_ENTRY,
      S_CHECK,
      S_WAIT,
      S_WON,
      S_LOST
   } state_t;

   state_t         state, state_d;
   logic [15:0]    guess_d;
   logic [2:0]     entry_d;
   logic [3:0]     att_d;
   logic [3:0]     ls_d;
   logic [3:0]     lb_d;
   logic [TW-1:0]  tmo_cnt, tmo_d;
   logic           rej_d;
   logic           dup_hit;

`ifdef DUP_REJECT_EN
   // Empty slots hold 4'hF, which never equals an accepted digit, so all slots can be compared.
   assign dup_hit = (guess[15:12] == digit) || (guess[11:8] == digit) ||
                    (guess[7:4]   == digit) || (guess[3:0]  == digit);
`else
   assign dup_hit = 1'b0;
`endif

   always_comb begin
      state_d = state;
      guess_d = guess;
      entry_d = entry_cnt;
      att_d   = attempts;
      ls_d    = last_strike;
      lb_d    = last_ball;
      tmo_d   = tmo_cnt;
      rej_d   = 1'b0;
      case (state)
         S_ENTRY: begin
            if (clear) begin
               guess_d = '1;
               entry_d = '0;
            end else if (digit_valid) begin
               if (digit > 4'd9 || dup_hit) begin
                  rej_d = 1'b1;
               end else begin
                  case (entry_cnt[1:0])
                     2'd0:    guess_d[15:12] = digit;
                     2'd1:    guess_d[11:8]  = digit;
                     2'd2:    guess_d[7:4]   = digit;
                     default: guess_d[3:0]   = digit;
                  endcase
                  entry_d = entry_cnt + 3'd1;
                  if (entry_cnt == 3'd3) state_d = S_CHECK;
               end
            end
         end
         S_CHECK: begin
            state_d = S_WAIT;
            tmo_d   = '0;
         end
         S_WAIT: begin
            if (clear) begin
               state_d = S_ENTRY;
               guess_d = '1;
               entry_d = '0;
            end else if (score_valid) begin
               ls_d  = strike;
               lb_d  = ball;
               att_d = attempts + 4'd1;
               if (strike == 4'd4) begin
                  state_d = S_WON;
               end else if (att_d == 4'(MAX_TRIES)) begin
                  state_d = S_LOST;
               end else begin
                  state_d = S_ENTRY;
                  guess_d = '1;
                  entry_d = '0;
               end
            end else if (tmo_cnt == TW'(RESULT_TMO - 1)) begin
               rej_d   = 1'b1;
               state_d = S_ENTRY;
               guess_d = '1;
               entry_d = '0;
            end else begin
               tmo_d = tmo_cnt + TW'(1);
            end
         end
         S_WON, S_LOST: begin
            if (clear) begin
               state_d = S_ENTRY;
               att_d   = '0;
               guess_d = '1;
               entry_d = '0;
            end
         end
         default: state_d = S_ENTRY;
      endcase
   end

   // check_en follows the CHECK cycle itself; win/lose/busy follow the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_ENTRY;
         guess       <= '1;
         entry_cnt   <= '0;
         attempts    <= '0;
         last_strike <= '0;
         last_ball   <= '0;
         tmo_cnt     <= '0;
         check_en    <= 1'b0;
         busy        <= 1'b0;
         reject      <= 1'b0;
         win         <= 1'b0;
         lose        <= 1'b0;
      end else begin
         state       <= state_d;
         guess       <= guess_d;
         entry_cnt   <= entry_d;
         attempts    <= att_d;
         last_strike <= ls_d;
         last_ball   <= lb_d;
         tmo_cnt     <= tmo_d;
         check_en    <= (state == S_CHECK);
         busy        <= (state_d == S_CHECK) || (state_d == S_WAIT);
         reject      <= rej_d;
         win         <= (state_d == S_WON);
         lose        <= (state_d == S_LOST);
      end
   end

endmodule

// File: tb/tb_guess_round_ctrl.sv
// Randomized bench for guess_round_ctrl against a queue-based game model.
module tb_guess_round_ctrl;

   localparam int unsigned MAXT = 3;
   localparam int unsigned TMO  = 5;

   logic        clk = 1'b0;
   logic        rst, digit_valid, clear, score_valid;
   logic [3:0]  digit, strike, ball;
   logic [15:0] guess;
   logic        check_en, busy, reject, win, lose;
   logic [2:0]  entry_cnt;
   logic [3:0]  attempts, last_strike, last_ball;

   int n_checks = 0;
   int n_fail   = 0;

   // model: entered digits, cycles since the guess became full (0 = entering), game-over flags
   int       q[$];
   int       age;
   bit       over, m_win, m_lose, m_rej, m_chk;
   int       m_att;
   int       m_ls, m_lb;

   guess_round_ctrl #(.MAX_TRIES(MAXT), .RESULT_TMO(TMO)) dut (
      .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit), .clear(clear),
      .score_valid(score_valid), .strike(strike), .ball(ball), .guess(guess),
      .check_en(check_en), .entry_cnt(entry_cnt), .attempts(attempts),
      .last_strike(last_strike), .last_ball(last_ball), .busy(busy),
      .reject(reject), .win(win), .lose(lose)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] model_guess();
      logic [15:0] g = 16'hFFFF;
      for (int i = 0; i < q.size(); i++) g[15-4*i -: 4] = 4'(q[i]);
      return g;
   endfunction

   task automatic model_step();
      bit dup = 0;
      m_rej = 0;
      m_chk = 0;
      if (rst) begin
         q.delete(); age = 0; over = 0; m_win = 0; m_lose = 0;
         m_att = 0; m_ls = 0; m_lb = 0;
      end else if (over) begin
         if (clear) begin
            over = 0; m_win = 0; m_lose = 0; m_att = 0; q.delete();
         end
      end else if (age == 0) begin
         if (clear) q.delete();
         else if (digit_valid) begin
`ifdef DUP_REJECT_EN
            foreach (q[i]) if (q[i] == int'(digit)) dup = 1;
`endif
            if (digit > 9 || dup) m_rej = 1;
            else begin
               q.push_back(int'(digit));
               if (q.size() == 4) age = 1;
            end
         end
      end else if (age == 1) begin
         age = 2;
         m_chk = 1;
      end else begin
         if (clear) begin
            age = 0; q.delete();
         end else if (score_valid) begin
            m_ls = int'(strike); m_lb = int'(ball); m_att++;
            age = 0;
            if (strike == 4) begin over = 1; m_win = 1; end
            else if (m_att == int'(MAXT)) begin over = 1; m_lose = 1; end
            else q.delete();
         end else if (age == int'(TMO) + 1) begin
            m_rej = 1; age = 0; q.delete();
         end else age++;
      end
   endtask

   task automatic compare_all();
      check("guess",       guess,              model_guess());
      check("entry_cnt",   16'(entry_cnt),     16'(q.size()));
      check("attempts",    16'(attempts),      16'(m_att));
      check("last_strike", 16'(last_strike),   16'(m_ls));
      check("last_ball",   16'(last_ball),     16'(m_lb));
      check("busy",        16'(busy),          16'(age >= 1));
      check("check_en",    16'(check_en),      16'(m_chk));
      check("reject",      16'(reject),        16'(m_rej));
      check("win",         16'(win),           16'(m_win));
      check("lose",        16'(lose),          16'(m_lose));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
      rst = 0; digit_valid = 0; clear = 0; score_valid = 0;
   endtask

   task automatic enter(input int d);
      digit_valid = 1; digit = 4'(d);
      tick();
   endtask

   task automatic score(input int s, input int b);
      score_valid = 1; strike = 4'(s); ball = 4'(b);
      tick();
   endtask

   task automatic full_guess(input int a, input int b, input int c, input int d);
      enter(a); enter(b); enter(c); enter(d);
      tick();
   endtask

   initial begin
      bit saw_rej;
      int att_keep;
      rst = 1; digit_valid = 0; clear = 0; score_valid = 0;
      digit = 0; strike = 0; ball = 0;
      tick();
      check("rst_guess", guess, 16'hFFFF);

      enter(1); enter(2); enter(3); enter(4);
      check("t1_guess", guess, 16'h1234);
      check("t1_chk_early", 16'(check_en), 16'd0);
      tick();
      check("t1_chk", 16'(check_en), 16'd1);
      score(4, 0);
      check("t2_win", 16'(win), 16'd1);
      check("t2_att", 16'(attempts), 16'd1);
      clear = 1; tick();
      check("t2_clr", {win, 3'b0, attempts, guess[7:0]}, 16'h00FF);

      for (int g = 0; g < 3; g++) begin
         full_guess(5, 6, 7, 8);
         score(1, 2);
      end
      check("t3_lose", 16'(lose), 16'd1);
      check("t3_att",  16'(attempts), 16'd3);
      clear = 1; tick();

      enter(10);
      check("t4_rej", 16'(reject), 16'd1);
      enter(5); enter(6);
      clear = 1; digit_valid = 1; digit = 4'd7; tick();
      check("t4_clr", {13'b0, entry_cnt}, 16'd0);

      full_guess(1, 3, 5, 7);
      score(0, 1);
      att_keep = int'(attempts);
      full_guess(2, 4, 6, 8);
      saw_rej = 0;
      for (int i = 0; i < int'(TMO) + 1; i++) begin
         tick();
         saw_rej |= reject;
      end
      check("t5_rej", 16'(saw_rej), 16'd1);
      score(4, 0);
      check("t5_att", 16'(attempts), 16'(att_keep));
      check("t5_nowin", 16'(win), 16'd0);

      enter(7); enter(7);
`ifdef DUP_REJECT_EN
      check("t6_guess", guess, 16'h7FFF);
`else
      check("t6_guess", guess, 16'h77FF);
`endif
      clear = 1; tick();

      for (int c = 0; c < 4000; c++) begin
         rst         = ($urandom_range(0, 999) == 0);
         digit_valid = ($urandom_range(0, 9) < 4);
         digit       = 4'($urandom_range(0, 11));
         clear       = ($urandom_range(0, 99) < 3);
         score_valid = ($urandom_range(0, 99) < 15);
         strike      = 4'($urandom_range(0, 4));
         ball        = 4'($urandom_range(0, 4));
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
